// File: rtl/nes_joy_serial_port.sv
// Serial controller ports $4016/$4017: latch joypad/powerpad state on strobe, shift one bit per read.
// Optional autofire on A/B is enabled by defining NES_JOY_TURBO_EN.
module nes_joy_serial_port #(
    parameter int TURBO_PERIOD = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        strobe,
    input  logic        rd0,
    input  logic        rd1,
    input  logic [7:0]  joy0,
    input  logic [7:0]  joy1,
    input  logic [11:0] powerpad,
    input  logic        pp_en,
    output logic        dout0,
    output logic [2:0]  dout1
`ifdef NES_JOY_TURBO_EN
    ,
    input  logic [1:0]  turbo0,
    input  logic [1:0]  turbo1
`endif
);

    localparam logic [3:0] CNT_MAX = 4'd8;

    // A zero period has no meaningful turbo rate; the empty block marks it as unsupported.
    if (TURBO_PERIOD < 1) begin : g_turbo_period_invalid
    end

    logic [7:0] sh0, sh1, sh_a, sh_b;
    logic [3:0] cnt0, cnt1;
    logic [7:0] joy0_ld, joy1_ld;

`ifdef NES_JOY_TURBO_EN
    localparam int TW = (TURBO_PERIOD > 1) ? $clog2(TURBO_PERIOD) : 1;

    logic [TW-1:0] turbo_cnt;
    logic          phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            turbo_cnt <= '0;
            phase     <= 1'b0;
        end else if (ce) begin
            if (turbo_cnt == TW'(TURBO_PERIOD - 1)) begin
                turbo_cnt <= '0;
                phase     <= ~phase;
            end else begin
                turbo_cnt <= turbo_cnt + 1'b1;
            end
        end
    end

    // Autofire masks A/B with the square wave only where the turbo bit is set.
    assign joy0_ld = {joy0[7:2], joy0[1] & (~turbo0[1] | phase), joy0[0] & (~turbo0[0] | phase)};
    assign joy1_ld = {joy1[7:2], joy1[1] & (~turbo1[1] | phase), joy1[0] & (~turbo1[0] | phase)};
`else
    assign joy0_ld = joy0;
    assign joy1_ld = joy1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sh0  <= 8'hFF;
            sh1  <= 8'hFF;
            sh_a <= 8'hFF;
            sh_b <= 8'hFF;
            cnt0 <= CNT_MAX;
            cnt1 <= CNT_MAX;
        end else if (ce) begin
            if (strobe) begin
                sh0  <= joy0_ld;
                sh1  <= joy1_ld;
                sh_a <= powerpad[7:0];
                sh_b <= {4'hF, powerpad[11:8]};
                cnt0 <= '0;
                cnt1 <= '0;
            end else begin
                // Shifting fills with 1s, so once saturated further reads are no-ops.
                if (rd0 && cnt0 != CNT_MAX) begin
                    sh0  <= {1'b1, sh0[7:1]};
                    cnt0 <= cnt0 + 4'd1;
                end
                if (rd1 && cnt1 != CNT_MAX) begin
                    sh1  <= {1'b1, sh1[7:1]};
                    sh_a <= {1'b1, sh_a[7:1]};
                    sh_b <= {1'b1, sh_b[7:1]};
                    cnt1 <= cnt1 + 4'd1;
                end
            end
        end
    end

    assign dout0 = sh0[0];
    assign dout1 = pp_en ? {sh_b[0], sh_a[0], 1'b0} : {2'b00, sh1[0]};

endmodule
